float_class_stats: RTL

- Stage directly downstream of the single-precision classification logic.
- Accepts a stream of IEEE-754 binary32 words over a valid/ready handshake.
- Classifies each word into the team's one-hot float-type code, registers it into a one-entry output stage with its own valid/ready, and keeps saturating per-class occurrence counters readable by the datapath/testbench.

---
 rtl/float_class_stats_pkg.sv | 38 +++
 rtl/float_class_decode.sv | 27 ++
 rtl/float_class_stats.sv | 124 ++++++++++++
 3 files changed

// File: rtl/float_class_stats_pkg.sv
// Shared definitions for the binary32 classification stages: one-hot class codes,
// field positions and a few helpers used by the decoder and the statistics block.
package float_class_stats_pkg;

  localparam logic [4:0] FT_ZERO = 5'b00001;
  localparam logic [4:0] FT_NORM = 5'b00010;
  localparam logic [4:0] FT_SUB  = 5'b00100;
  localparam logic [4:0] FT_INF  = 5'b01000;
  localparam logic [4:0] FT_NAN  = 5'b10000;

  localparam int unsigned NUM_CLASSES = 5;

  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Bit position of each class inside the one-hot code.
  typedef enum logic [2:0] {
    ClsZero = 3'd0,
    ClsNorm = 3'd1,
    ClsSub  = 3'd2,
    ClsInf  = 3'd3,
    ClsNan  = 3'd4
  } cls_idx_e;

  function automatic logic is_one_hot5(logic [4:0] t);
    return (t != 5'd0) && ((t & (t - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/float_class_decode.sv
// Pure combinational binary32 classifier producing the one-hot float-type code.
// The sign bit does not influence the class.
module float_class_decode
  import float_class_stats_pkg::*;
(
  input  logic [31:0] num_i,
  output logic [4:0]  type_o
);

  fp32_t f;
  logic  frac_nz;
  logic  unused_sign;

  assign f           = fp32_t'(num_i);
  assign frac_nz     = |f.frac;
  assign unused_sign = f.sign;

  always_comb begin
    type_o = FT_NORM;
    if (f.exp == EXP_ALL_ONES) begin
      type_o = frac_nz ? FT_NAN : FT_INF;
    end else if (f.exp == 8'h00) begin
      type_o = frac_nz ? FT_SUB : FT_ZERO;
    end
  end

endmodule

// File: rtl/float_class_stats.sv
// Classifies a valid/ready stream of binary32 words into a one-entry output register
// and keeps saturating per-class occurrence counters plus a sticky NaN flag.
module float_class_stats
  import float_class_stats_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_num,
  output logic [4:0]       out_type,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_norm,
  output logic [CNT_W-1:0] cnt_sub,
  output logic [CNT_W-1:0] cnt_inf,
  output logic [CNT_W-1:0] cnt_nan,
  output logic             any_nan
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [4:0]  num_type;
  logic        accept;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_num_q, out_num_d;
  logic [4:0]  out_type_q, out_type_d;
  logic        any_nan_q, any_nan_d;

  float_class_decode u_decode (
    .num_i  (num),
    .type_o (num_type)
  );

  // Reset gates in_ready so nothing is accepted while the block is held in reset.
  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_num_d   = out_num_q;
    out_type_d  = out_type_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_num_d   = num;
      out_type_d  = num_type;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    any_nan_d = any_nan_q;
    if (clear) begin
      any_nan_d = 1'b0;
    end else if (accept && num_type[ClsNan]) begin
      any_nan_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_num_q   <= 32'h0;
      out_type_q  <= 5'b00000;
      any_nan_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
      out_type_q  <= out_type_d;
      any_nan_q   <= any_nan_d;
    end
  end

  // One saturating counter per class; clear wins over a same-cycle accept.
  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (accept && num_type[i] && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CntOne;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign cnt_zero  = g_cnt[0].cnt_q;
  assign cnt_norm  = g_cnt[1].cnt_q;
  assign cnt_sub   = g_cnt[2].cnt_q;
  assign cnt_inf   = g_cnt[3].cnt_q;
  assign cnt_nan   = g_cnt[4].cnt_q;

  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_type  = out_type_q;
  assign any_nan   = any_nan_q;

  a_type_onehot: assert property (@(posedge clk) disable iff (reset)
    out_valid_q |-> is_one_hot5(out_type_q));

  a_hold_stalled: assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !out_ready) |=> ($stable(out_num_q) && $stable(out_type_q) && out_valid_q));

  a_decode_onehot: assert property (@(posedge clk) disable iff (reset)
    is_one_hot5(num_type));

endmodule
